// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control path.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_R    = 4'd3,
    S_EXEC_I    = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_LOAD_ACC  = 4'd6,
    S_STORE_ACC = 4'd7,
    S_BRANCH    = 4'd8,
    S_JAL       = 4'd9,
    S_WB_ALU    = 4'd10,
    S_WB_MEM    = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_R   = 2'b00;
  localparam logic [1:0] ALUOP_I   = 2'b01;
  localparam logic [1:0] ALUOP_BR  = 2'b10;
  localparam logic [1:0] ALUOP_ADD = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Handshake with the shared instruction/data memory port.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_opcode_class_dec.sv
// Maps an instruction opcode to the state that follows DECODE.
module opcode_class_dec
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output state_t     next_state,
  output logic       is_store
);

  // Unknown opcodes fall through to TRAP so the core halts on garbage.
  always_comb begin
    next_state = S_TRAP;
    is_store   = (opcode == OPC_STORE);
    case (opcode)
      OPC_R:      next_state = S_EXEC_R;
      OPC_I:      next_state = S_EXEC_I;
      OPC_LOAD:   next_state = S_MEM_ADDR;
      OPC_STORE:  next_state = S_MEM_ADDR;
      OPC_BRANCH: next_state = S_BRANCH;
      OPC_JAL:    next_state = S_JAL;
      default:    next_state = S_TRAP;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core plus retired-instruction counter.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        opcode,
  input  logic              br_taken,
  multicycle_ctrl_if.master bus,
  output logic              ir_we,
  output logic              mdr_we,
  output logic              pc_we,
  output logic              reg_we,
  output logic              pc_sel,
  output logic [1:0]        alu_op,
  output logic              alu_src_a,
  output logic              alu_src_b,
  output logic [1:0]        wb_sel,
  output logic              illegal,
  output logic              retire,
  output logic [CNT_W-1:0]  instret
);

  state_t           state;
  state_t           state_next;
  state_t           dec_next;
  logic             dec_store;
  logic [CNT_W-1:0] instret_q;

  opcode_class_dec u_dec (
    .opcode     (opcode),
    .next_state (dec_next),
    .is_store   (dec_store)
  );

  // State register; reset parks the FSM in IDLE even mid-access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state selection; mem_ready only matters in the access states.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      state_next = S_FETCH;
      S_FETCH:     state_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:    state_next = dec_next;
      S_EXEC_R:    state_next = S_WB_ALU;
      S_EXEC_I:    state_next = S_WB_ALU;
      S_MEM_ADDR:  state_next = dec_store ? S_STORE_ACC : S_LOAD_ACC;
      S_LOAD_ACC:  state_next = bus.mem_ready ? S_WB_MEM : S_LOAD_ACC;
      S_STORE_ACC: state_next = bus.mem_ready ? S_FETCH : S_STORE_ACC;
      S_BRANCH:    state_next = S_FETCH;
      S_JAL:       state_next = S_FETCH;
      S_WB_ALU:    state_next = S_FETCH;
      S_WB_MEM:    state_next = S_FETCH;
      S_TRAP:      state_next = S_TRAP;
      default:     state_next = S_IDLE;
    endcase
  end

  // Moore output decode; write enables in access states wait for mem_ready.
  always_comb begin
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.addr_sel = 1'b0;
    ir_we        = 1'b0;
    mdr_we       = 1'b0;
    pc_we        = 1'b0;
    reg_we       = 1'b0;
    pc_sel       = 1'b0;
    alu_op       = ALUOP_R;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    wb_sel       = WB_ALU;
    illegal      = 1'b0;
    retire       = 1'b0;
    case (state)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        ir_we       = bus.mem_ready;
      end
      S_EXEC_R: begin
        alu_op    = ALUOP_R;
        alu_src_b = 1'b0;
      end
      S_EXEC_I: begin
        alu_op    = ALUOP_I;
        alu_src_b = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_op    = ALUOP_ADD;
        alu_src_b = 1'b1;
      end
      S_LOAD_ACC: begin
        bus.mem_req  = 1'b1;
        bus.addr_sel = 1'b1;
        mdr_we       = bus.mem_ready;
      end
      S_STORE_ACC: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b1;
        bus.addr_sel = 1'b1;
        pc_we        = bus.mem_ready;
        retire       = bus.mem_ready;
      end
      S_BRANCH: begin
        alu_op = ALUOP_BR;
        pc_we  = 1'b1;
        pc_sel = br_taken;
        retire = 1'b1;
      end
      S_JAL: begin
        alu_op    = ALUOP_ADD;
        alu_src_a = 1'b1;
        alu_src_b = 1'b1;
        reg_we    = 1'b1;
        wb_sel    = WB_PC4;
        pc_we     = 1'b1;
        pc_sel    = 1'b1;
        retire    = 1'b1;
      end
      S_WB_ALU: begin
        reg_we = 1'b1;
        wb_sel = WB_ALU;
        pc_we  = 1'b1;
        retire = 1'b1;
      end
      S_WB_MEM: begin
        reg_we = 1'b1;
        wb_sel = WB_MDR;
        pc_we  = 1'b1;
        retire = 1'b1;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: begin
        illegal = 1'b0;
      end
    endcase
  end

  // Retired-instruction counter; wraps naturally at the top of its range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret_q <= '0;
    else if (retire) instret_q <= instret_q + CNT_W'(1);
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for the multi-cycle control FSM.
module tb_multicycle_ctrl;
  import riscv_ctrl_pkg::*;

  // Expected output vectors, bit order:
  // mem_req mem_we addr_sel ir_we mdr_we pc_we reg_we pc_sel alu_op[1:0] alu_src_a alu_src_b wb_sel[1:0] illegal retire
  localparam logic [15:0] E_ZERO     = 16'h0000;
  localparam logic [15:0] E_FETCH_W  = 16'h8000;
  localparam logic [15:0] E_FETCH_R  = 16'h9000;
  localparam logic [15:0] E_EXEC_I   = 16'h0050;
  localparam logic [15:0] E_MEM_ADDR = 16'h00D0;
  localparam logic [15:0] E_LOAD_W   = 16'hA000;
  localparam logic [15:0] E_LOAD_R   = 16'hA800;
  localparam logic [15:0] E_STORE_W  = 16'hE000;
  localparam logic [15:0] E_STORE_R  = 16'hE401;
  localparam logic [15:0] E_BR_T     = 16'h0581;
  localparam logic [15:0] E_BR_NT    = 16'h0481;
  localparam logic [15:0] E_JAL      = 16'h07F9;
  localparam logic [15:0] E_WB_ALU   = 16'h0601;
  localparam logic [15:0] E_WB_MEM   = 16'h0605;
  localparam logic [15:0] E_TRAP     = 16'h0002;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        br_taken;
  logic        ir_we, mdr_we, pc_we, reg_we, pc_sel;
  logic [1:0]  alu_op;
  logic        alu_src_a, alu_src_b;
  logic [1:0]  wb_sel;
  logic        illegal, retire;
  logic [31:0] instret;
  logic [15:0] outs;

  int checks_total;
  int checks_passed;

  multicycle_ctrl_if mif ();

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .br_taken  (br_taken),
    .bus       (mif.master),
    .ir_we     (ir_we),
    .mdr_we    (mdr_we),
    .pc_we     (pc_we),
    .reg_we    (reg_we),
    .pc_sel    (pc_sel),
    .alu_op    (alu_op),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .wb_sel    (wb_sel),
    .illegal   (illegal),
    .retire    (retire),
    .instret   (instret)
  );

  assign outs = {mif.mem_req, mif.mem_we, mif.addr_sel, ir_we, mdr_we, pc_we, reg_we,
                 pc_sel, alu_op, alu_src_a, alu_src_b, wb_sel, illegal, retire};

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    checks_total++;
    if (got === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expected);
  endtask

  task automatic applyStimulus(input logic [6:0] opc, input logic rdy, input logic brt);
    opcode        = opc;
    mif.mem_ready = rdy;
    br_taken      = brt;
  endtask

  // Check the current cycle's outputs, then move on to the next cycle.
  task automatic expectCycle(input string tag, input logic [15:0] expected);
    #1;
    checkOutput(tag, {16'h0, outs}, {16'h0, expected});
    @(negedge clk);
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst_n = 1'b0;
    applyStimulus(OPC_R, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset_outs", {16'h0, outs}, 32'h0);
    checkOutput("reset_instret", instret, 32'd0);
    @(negedge clk);

    // R-type, zero wait
    rst_n = 1'b1;
    expectCycle("r_idle", E_ZERO);
    expectCycle("r_fetch", E_FETCH_R);
    expectCycle("r_decode", E_ZERO);
    expectCycle("r_exec", E_ZERO);
    checkOutput("r_instret_pre", instret, 32'd0);
    expectCycle("r_wb", E_WB_ALU);

    // Load with one fetch wait and three data waits
    applyStimulus(OPC_LOAD, 1'b0, 1'b0);
    #1;
    checkOutput("r_instret", instret, 32'd1);
    expectCycle("ld_fetch_wait", E_FETCH_W);
    applyStimulus(OPC_LOAD, 1'b1, 1'b0);
    expectCycle("ld_fetch", E_FETCH_R);
    expectCycle("ld_decode", E_ZERO);
    applyStimulus(OPC_LOAD, 1'b0, 1'b0);
    expectCycle("ld_addr", E_MEM_ADDR);
    for (int i = 0; i < 3; i++) expectCycle($sformatf("ld_wait%0d", i), E_LOAD_W);
    applyStimulus(OPC_LOAD, 1'b1, 1'b0);
    expectCycle("ld_ready", E_LOAD_R);
    expectCycle("ld_wb", E_WB_MEM);
    #1;
    checkOutput("ld_instret", instret, 32'd2);

    // Branch taken, then not taken
    applyStimulus(OPC_BRANCH, 1'b1, 1'b1);
    expectCycle("brt_fetch", E_FETCH_R);
    expectCycle("brt_decode", E_ZERO);
    expectCycle("brt_exec", E_BR_T);
    applyStimulus(OPC_BRANCH, 1'b1, 1'b0);
    expectCycle("brn_fetch", E_FETCH_R);
    expectCycle("brn_decode", E_ZERO);
    expectCycle("brn_exec", E_BR_NT);
    #1;
    checkOutput("br_instret", instret, 32'd4);

    // JAL retiring across the counter wrap
    applyStimulus(OPC_JAL, 1'b1, 1'b0);
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    expectCycle("jal_fetch", E_FETCH_R);
    checkOutput("jal_preload", instret, 32'hFFFF_FFFF);
    expectCycle("jal_decode", E_ZERO);
    expectCycle("jal_exec", E_JAL);
    #1;
    checkOutput("jal_wrap", instret, 32'd0);

    // Store with one data wait
    applyStimulus(OPC_STORE, 1'b1, 1'b0);
    expectCycle("st_fetch", E_FETCH_R);
    expectCycle("st_decode", E_ZERO);
    applyStimulus(OPC_STORE, 1'b0, 1'b0);
    expectCycle("st_addr", E_MEM_ADDR);
    expectCycle("st_wait", E_STORE_W);
    applyStimulus(OPC_STORE, 1'b1, 1'b0);
    expectCycle("st_ready", E_STORE_R);
    #1;
    checkOutput("st_instret", instret, 32'd1);

    // Illegal opcode: sticky trap, memory ready ignored, counter frozen
    applyStimulus(7'b0000000, 1'b1, 1'b0);
    expectCycle("trap_fetch", E_FETCH_R);
    expectCycle("trap_decode", E_ZERO);
    for (int i = 0; i < 20; i++) expectCycle($sformatf("trap_hold%0d", i), E_TRAP);
    #1;
    checkOutput("trap_instret", instret, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("trap_clear", {16'h0, outs}, 32'h0);
    checkOutput("trap_clear_cnt", instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Store interrupted by reset while waiting on memory
    applyStimulus(OPC_STORE, 1'b1, 1'b0);
    expectCycle("rs_idle", E_ZERO);
    expectCycle("rs_fetch", E_FETCH_R);
    expectCycle("rs_decode", E_ZERO);
    applyStimulus(OPC_STORE, 1'b0, 1'b0);
    expectCycle("rs_addr", E_MEM_ADDR);
    expectCycle("rs_wait", E_STORE_W);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rs_drop", {16'h0, outs}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(OPC_R, 1'b1, 1'b0);
    #1;
    checkOutput("rs_instret", instret, 32'd0);
    expectCycle("rs_idle2", E_ZERO);
    expectCycle("rs_fetch2", E_FETCH_R);

    // I-type for coverage of the immediate ALU path
    applyStimulus(OPC_I, 1'b1, 1'b0);
    expectCycle("i_decode", E_ZERO);
    expectCycle("i_exec", E_EXEC_I);
    expectCycle("i_wb", E_WB_ALU);
    #1;
    checkOutput("i_instret", instret, 32'd1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback. Each cycle it drives the 2-bit `alu_op` class consumed by the ALU control decoder, plus the datapath mux selects and write enables. It also handshakes with the shared instruction/data memory port and counts retired instructions.

## Interface
- `CNT_W`, 32: width of retired-instruction counter.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `opcode` in 7: IR[6:0], stable from DECODE onward.
- `mem_ready` in 1: memory completes access this cycle.
- `br_taken` in 1: branch comparator result, valid in BRANCH.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: 1 = store.
- `addr_sel` out 1: 0 = PC, 1 = ALU result register.
- `ir_we`, `mdr_we`, `pc_we`, `reg_we` out 1 each: register write enables.
- `pc_sel` out 1: 0 = PC+4, 1 = target from ALU.
- `alu_op` out 2: 00 R, 01 I, 10 branch compare, 11 add (address/JAL).
- `alu_src_a` out 1: 0 = rs1, 1 = PC.
- `alu_src_b` out 1: 0 = rs2, 1 = immediate.
- `wb_sel` out 2: 00 ALU, 01 MDR, 10 PC+4.
- `illegal` out 1: sticky illegal-opcode flag.
- `retire` out 1: one-cycle pulse per completed instruction.
- `instret` out CNT_W: retired count.

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, LOAD_ACC, STORE_ACC, BRANCH, JAL, WB_ALU, WB_MEM, TRAP.
- Outputs are Moore-decoded from the state, except that enables in access states are gated by `mem_ready`. Any output not listed for a state is 0.
- IDLE: reached only from reset. Always moves to FETCH next cycle.
- FETCH: `mem_req`=1, `addr_sel`=0. Stays in FETCH while `mem_ready`=0. When `mem_ready`=1: `ir_we`=1 and move to DECODE.
- DECODE: the opcode selects the next state.
  - 0110011 → EXEC_R.
  - 0010011 → EXEC_I.
  - 0000011 or 0100011 → MEM_ADDR.
  - 1100011 → BRANCH.
  - 1101111 → JAL.
  - Any other opcode → TRAP.
- EXEC_R: `alu_op`=00, `alu_src_b`=0. Next state WB_ALU.
- EXEC_I: `alu_op`=01, `alu_src_b`=1. Next state WB_ALU.
- MEM_ADDR: `alu_op`=11, `alu_src_b`=1. Next state is LOAD_ACC for a load, STORE_ACC for a store.
- LOAD_ACC: `mem_req`=1, `addr_sel`=1. When `mem_ready`=1: `mdr_we`=1 and move to WB_MEM.
- STORE_ACC: `mem_req`=1, `mem_we`=1, `addr_sel`=1. When `mem_ready`=1: `pc_we`=1, `pc_sel`=0, `retire`=1, move to FETCH.
- BRANCH: `alu_op`=10, `alu_src_b`=0, `pc_we`=1, `pc_sel`=`br_taken`, `retire`=1. Next state FETCH.
- JAL: `alu_op`=11, `alu_src_a`=1, `alu_src_b`=1, `reg_we`=1, `wb_sel`=10, `pc_we`=1, `pc_sel`=1, `retire`=1. Next state FETCH.
- WB_ALU: `reg_we`=1, `wb_sel`=00, `pc_we`=1, `pc_sel`=0, `retire`=1. Next state FETCH.
- WB_MEM: `reg_we`=1, `wb_sel`=01, `pc_we`=1, `pc_sel`=0, `retire`=1. Next state FETCH.
- TRAP: `illegal`=1 and all enables are 0. Stays in TRAP until reset; `instret` is frozen.
- `instret` increments on every cycle with `retire`=1 and wraps from 2^CNT_W−1 to 0.
- `mem_ready` is ignored outside FETCH, LOAD_ACC and STORE_ACC.

## Timing
- Reset (`rst_n` low, at any time, including mid-access): state goes to IDLE immediately. All outputs are 0, `instret`=0, `illegal`=0.
- The first `mem_req` appears in the cycle after `rst_n` rises.
- Latency from FETCH entry to `retire`, with zero memory wait:
  - R-type and I-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch and JAL: 3 cycles.
- Each cycle of `mem_ready`=0 in an access state adds 1 cycle.
- While waiting, `mem_req`, `mem_we` and `addr_sel` stay constant.
- `retire` and `pc_we` are always asserted in the same cycle. The next FETCH starts the following cycle, so there are no back-to-back retires.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - the state enum;
  - opcode constants (OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL);
  - `alu_op` encodings (ALUOP_R, ALUOP_I, ALUOP_BR, ALUOP_ADD);
  - `wb_sel` encodings (WB_ALU, WB_MDR, WB_PC4).
- One sub-module, `opcode_class_dec`: combinational opcode → next-state/class decode, used in DECODE.
- The state register and `instret` counter stay in the top module.

## Test plan
- Reset release, opcode 0110011, `mem_ready` held 1 → IDLE, then FETCH; `ir_we` at cycle 1; EXEC_R shows `alu_op`=00; WB_ALU shows `reg_we`=1 and `retire`=1; `instret`=1.
- Load (0000011), `mem_ready` low 3 cycles in LOAD_ACC → `mem_req`/`addr_sel`=1 held steady; `mdr_we` only on the ready cycle; `retire` 8 cycles after FETCH entry.
- Branch (1100011) with `br_taken`=1, then again with `br_taken`=0 → `pc_sel`=1, then 0; `alu_op`=10 in both; `reg_we` never asserted.
- Opcode 0000000 → TRAP, `illegal`=1 sticky; `mem_req` stays 0 for 20 cycles; `rst_n` pulse clears `illegal`.
- `rst_n` asserted mid-STORE_ACC wait → `mem_req`/`mem_we` drop in the same cycle; `instret` is 0 after release.
- Preload `instret`=0xFFFF_FFFF via force, then retire one JAL → `instret`=0; `wb_sel`=10 and `alu_src_a`=1 during JAL.
